rsa_stream_seq: RTL and testbench
=================================

RSA_STREAM_SEQ -- requirements
Module: rsa_stream_seq

Interface
REQ-001 Parameter WIDTH, default 32, sets the p/q/message word width; core result width is 2*WIDTH.
REQ-002 Parameter SETTLE, default 2, sets the cycles core inputs are held stable before a start pulse.
REQ-003 Parameter TIMEOUT, default 65535, sets the maximum RUN cycles allowed per operation.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 reset  in  1  asynchronous, active-low reset.
REQ-006 key_ready  in  1  high when encryption/decryption keys are valid (inverter finished).
REQ-007 in_valid / in_ready  in / out  1 / 1  input word handshake.
REQ-008 in_data  in  WIDTH  plaintext or ciphertext word.
REQ-009 in_mode  in  1  1 = encrypt, 0 = decrypt; sampled with in_data.
REQ-010 core_msg  out  WIDTH  message to RSA core msg_in, held from accept until DONE.
REQ-011 core_mode  out  1  to RSA core encrypt_decrypt, held with core_msg.
REQ-012 core_start  out  1  active-high restart to RSA core mod_exp reset input.
REQ-013 core_finish  in  1  RSA core mod_exp finish flag.
REQ-014 core_result  in  2*WIDTH  RSA core msg_out.
REQ-015 out_valid / out_ready  out / in  1 / 1  result handshake.
REQ-016 out_data  out  2*WIDTH  captured result; out_mode  out  1  mode of that result.
REQ-017 busy  out  1  high in every state except IDLE.
REQ-018 done_count  out  16  completed operations, wraps 65535 -> 0.

Function
REQ-019 FSM states: IDLE, LOAD, START, ARM, RUN, DONE.
REQ-020 IDLE: in_ready = key_ready; on in_valid & in_ready, register in_data/in_mode into core_msg/core_mode, go LOAD.
REQ-021 LOAD: hold SETTLE cycles (covers the core's input register stage), then START.
REQ-022 START: core_start high exactly 2 cycles, then ARM.
REQ-023 ARM: 1 cycle with core_start low; core_finish is ignored (stale flag from the previous operation), then RUN.
REQ-024 RUN: on core_finish high, capture core_result into out_data and core_mode into out_mode in the same edge, go DONE.
REQ-025 DONE: out_valid high; on out_ready, increment done_count, go IDLE; out_data stable while out_valid & !out_ready.
REQ-026 in_ready is low in all non-IDLE states; at most one operation is in flight.
REQ-027 key_ready falling mid-operation does not abort the operation; it only gates the next accept in IDLE.
REQ-028 Accept-to-out_valid latency = SETTLE + 2 + 1 + N + 1 cycles, where N is the number of RUN cycles until core_finish.
REQ-029 out_valid & out_ready in the cycle after DONE entry returns the FSM to IDLE; the next accept is possible on the following edge.

Reset
REQ-030 When reset is asserted low: FSM = IDLE; in_ready, out_valid, core_start, busy = 0; core_msg, core_mode, out_data, out_mode, done_count = 0; all counters = 0; err_timeout = 0.
REQ-031 Reset asserted mid-operation takes effect immediately with no out_valid; the first accept after reset release is possible on the first edge with key_ready high.

Configuration
REQ-032 Macro RSA_SEQ_TIMEOUT_EN defined: add port err_timeout (out, 1, sticky); RUN counts cycles, and at TIMEOUT cycles without core_finish sets err_timeout, drops the word (no out_valid, done_count unchanged) and returns to IDLE; err_timeout clears only on reset.
REQ-033 Macro RSA_SEQ_TIMEOUT_EN undefined: no err_timeout port and no counter; RUN waits indefinitely.

Verification
REQ-034 Core model with n = 3233, e = 17, d = 2753, key_ready = 1; encrypt in_data = 65 -> out_data = 2790, out_mode = 1, done_count = 1.
REQ-035 Decrypt in_data = 2790 -> out_data = 65, out_mode = 0; latency matches REQ-028 for the model's N.
REQ-036 Core model holds core_finish high from the previous operation; a new encrypt of 65 still waits for the fresh finish pulse -> no early capture, out_data = 2790.
REQ-037 out_ready low for 10 cycles in DONE -> out_valid and out_data stable, in_ready = 0, a pending in_valid is not accepted until after the handshake.
REQ-038 reset asserted low during RUN -> all outputs at reset values next cycle, no out_valid; with key_ready = 0 after release -> in_ready stays 0.
REQ-039 With RSA_SEQ_TIMEOUT_EN and TIMEOUT = 100, core_finish tied low -> err_timeout = 1 after 100 RUN cycles, FSM in IDLE, done_count unchanged.

Source files
------------

// File: rtl/rsa_stream_seq.sv
// Stream sequencer wrapping an RSA mod_exp core: accepts one word, restarts the core, waits for a fresh finish, returns the result.
// Optional macro RSA_SEQ_TIMEOUT_EN adds a sticky err_timeout port and a bounded RUN wait.
module rsa_stream_seq #(
   parameter int unsigned WIDTH   = 32,
   parameter int unsigned SETTLE  = 2,
   parameter int unsigned TIMEOUT = 65535
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 key_ready,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [WIDTH-1:0]     in_data,
   input  logic                 in_mode,
   output logic [WIDTH-1:0]     core_msg,
   output logic                 core_mode,
   output logic                 core_start,
   input  logic                 core_finish,
   input  logic [2*WIDTH-1:0]   core_result,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [2*WIDTH-1:0]   out_data,
   output logic                 out_mode,
   output logic                 busy,
   output logic [15:0]          done_count
`ifdef RSA_SEQ_TIMEOUT_EN
   ,
   output logic                 err_timeout
`endif
);

   localparam int unsigned CNT_MAX   = (TIMEOUT > SETTLE) ? TIMEOUT : SETTLE;
   localparam int unsigned CNT_W     = $clog2(CNT_MAX + 2);
   localparam int unsigned LOAD_LAST = (SETTLE > 0) ? SETTLE - 1 : 0;
`ifdef RSA_SEQ_TIMEOUT_EN
   localparam int unsigned RUN_LAST  = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
`endif

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_START,
      S_ARM,
      S_RUN,
      S_DONE
   } state_t;

   state_t           state, state_d;
   logic [CNT_W-1:0] cnt, cnt_d;
   logic             accept, capture, retire, expire;

   // Accept gate is combinational so the first edge with key_ready high can accept.
   assign in_ready = reset && key_ready && (state == S_IDLE);

   // Next-state and per-transition strobes.
   always_comb begin
      state_d = state;
      cnt_d   = cnt;
      accept  = 1'b0;
      capture = 1'b0;
      retire  = 1'b0;
      expire  = 1'b0;
      case (state)
         S_IDLE: begin
            if (in_valid && in_ready) begin
               accept  = 1'b1;
               cnt_d   = '0;
               state_d = S_LOAD;
            end
         end
         S_LOAD: begin
            if (cnt == CNT_W'(LOAD_LAST)) begin
               cnt_d   = '0;
               state_d = S_START;
            end else begin
               cnt_d = cnt + CNT_W'(1);
            end
         end
         S_START: begin
            if (cnt == CNT_W'(1)) begin
               cnt_d   = '0;
               state_d = S_ARM;
            end else begin
               cnt_d = cnt + CNT_W'(1);
            end
         end
         // core_finish here may still be the previous operation's flag.
         S_ARM: begin
            cnt_d   = '0;
            state_d = S_RUN;
         end
         S_RUN: begin
            if (core_finish) begin
               capture = 1'b1;
               state_d = S_DONE;
            end
`ifdef RSA_SEQ_TIMEOUT_EN
            else if (cnt == CNT_W'(RUN_LAST)) begin
               expire  = 1'b1;
               state_d = S_IDLE;
            end else begin
               cnt_d = cnt + CNT_W'(1);
            end
`endif
         end
         S_DONE: begin
            if (out_ready) begin
               retire  = 1'b1;
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State, datapath and registered outputs.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= S_IDLE;
         cnt        <= '0;
         core_msg   <= '0;
         core_mode  <= 1'b0;
         core_start <= 1'b0;
         out_valid  <= 1'b0;
         out_data   <= '0;
         out_mode   <= 1'b0;
         busy       <= 1'b0;
         done_count <= '0;
`ifdef RSA_SEQ_TIMEOUT_EN
         err_timeout <= 1'b0;
`endif
      end else begin
         state      <= state_d;
         cnt        <= cnt_d;
         core_start <= (state_d == S_START);
         out_valid  <= (state_d == S_DONE);
         busy       <= (state_d != S_IDLE);
         if (accept) begin
            core_msg  <= in_data;
            core_mode <= in_mode;
         end
         if (capture) begin
            out_data <= core_result;
            out_mode <= core_mode;
         end
         if (retire) begin
            done_count <= done_count + 16'd1;
         end
`ifdef RSA_SEQ_TIMEOUT_EN
         if (expire) begin
            err_timeout <= 1'b1;
         end
`endif
      end
   end

endmodule

// File: tb/tb_rsa_stream_seq.sv
// Randomized bench for rsa_stream_seq against a toy RSA core (n=3233, e=17, d=2753) and an arithmetic reference.
// Exercises the RSA_SEQ_TIMEOUT_EN path too when that macro is defined.
module tb_rsa_stream_seq;

   localparam int unsigned WIDTH   = 32;
   localparam int unsigned SETTLE  = 2;
   localparam int unsigned TIMEOUT = 100;
   localparam longint unsigned RSA_N = 3233;
   localparam longint unsigned RSA_E = 17;
   localparam longint unsigned RSA_D = 2753;

   logic                 clk;
   logic                 reset;
   logic                 key_ready;
   logic                 in_valid;
   logic                 in_ready;
   logic [WIDTH-1:0]     in_data;
   logic                 in_mode;
   logic [WIDTH-1:0]     core_msg;
   logic                 core_mode;
   logic                 core_start;
   logic                 core_finish;
   logic [2*WIDTH-1:0]   core_result;
   logic                 out_valid;
   logic                 out_ready;
   logic [2*WIDTH-1:0]   out_data;
   logic                 out_mode;
   logic                 busy;
   logic [15:0]          done_count;
`ifdef RSA_SEQ_TIMEOUT_EN
   logic                 err_timeout;
`endif

   int n_checks = 0;
   int n_fails  = 0;
   int exp_done = 0;

   rsa_stream_seq #(.WIDTH(WIDTH), .SETTLE(SETTLE), .TIMEOUT(TIMEOUT)) dut (
      .clk         (clk),
      .reset       (reset),
      .key_ready   (key_ready),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_data     (in_data),
      .in_mode     (in_mode),
      .core_msg    (core_msg),
      .core_mode   (core_mode),
      .core_start  (core_start),
      .core_finish (core_finish),
      .core_result (core_result),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_data    (out_data),
      .out_mode    (out_mode),
      .busy        (busy),
      .done_count  (done_count)
`ifdef RSA_SEQ_TIMEOUT_EN
      ,
      .err_timeout (err_timeout)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic longint unsigned modexp(input longint unsigned b_in,
                                              input longint unsigned e_in,
                                              input longint unsigned m);
      longint unsigned r = 1;
      longint unsigned b = b_in % m;
      longint unsigned e = e_in;
      while (e > 0) begin
         if (e[0]) r = (r * b) % m;
         b = (b * b) % m;
         e = e >> 1;
      end
      return r;
   endfunction

   task automatic check(input string tag, input longint unsigned got, input longint unsigned exp);
      n_checks++;
      if (got !== exp) begin
         n_fails++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Toy core: restarts on core_start, computes after core_lat cycles, finish flag reaches the pin two cycles later and stays high.
   int         core_lat  = 1;
   logic       force_low = 1'b0;
   int         m_cnt     = 0;
   logic       m_run     = 1'b0;
   logic       fin_int   = 1'b0;
   logic       fin_d1    = 1'b0;
   logic [WIDTH-1:0] m_msg = '0;
   logic       m_mode    = 1'b0;
   initial begin
      core_finish = 1'b0;
      core_result = '0;
   end
   always @(posedge clk) begin
      if (core_start) begin
         m_run   <= 1'b1;
         m_cnt   <= 0;
         fin_int <= 1'b0;
         m_msg   <= core_msg;
         m_mode  <= core_mode;
      end else if (m_run) begin
         m_cnt <= m_cnt + 1;
         if (m_cnt + 1 == core_lat) begin
            fin_int     <= 1'b1;
            m_run       <= 1'b0;
            core_result <= 64'(modexp(64'(m_msg), m_mode ? RSA_E : RSA_D, RSA_N));
         end
      end
      fin_d1      <= fin_int;
      core_finish <= fin_d1 && !force_low;
   end

   // One full operation with latency, result, back-pressure and handshake checks.
   task automatic do_op(input logic [WIDTH-1:0] data, input logic mode, input int lat,
                        input int hold, input logic drop_key);
      longint unsigned exp_res;
      int exp_lat;
      int n;
      int lat_c;
      int starts;
      exp_res = modexp(64'(data), mode ? RSA_E : RSA_D, RSA_N);
      // Finish reaches the pin lat+2 cycles into RUN, i.e. after lat+1 RUN cycles without it.
      exp_lat = SETTLE + 2 + 1 + (lat + 1) + 1;
      core_lat = lat;
      in_data  = data;
      in_mode  = mode;
      in_valid = 1'b1;
      n = 0;
      while (!in_ready && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      check("accept_wait", (n < 50) ? 1 : 0, 1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      if (drop_key) key_ready = 1'b0;
      check("busy_after_accept", busy, 1);
      lat_c  = 0;
      starts = 0;
      while (!out_valid && lat_c < 300) begin
         @(posedge clk); #1;
         lat_c++;
         if (core_start) starts++;
      end
      key_ready = 1'b1;
      check("latency", lat_c, exp_lat);
      check("start_cycles", starts, 2);
      check("out_data", out_data, exp_res);
      check("out_mode", out_mode, mode);
      check("in_ready_done", in_ready, 0);
      in_data  = data ^ 1;
      in_mode  = ~mode;
      in_valid = (hold > 0);
      for (int i = 0; i < hold; i++) begin
         @(posedge clk); #1;
         check("hold_valid", out_valid, 1);
         check("hold_data", out_data, exp_res);
         check("hold_in_ready", in_ready, 0);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      exp_done  = (exp_done + 1) % 65536;
      check("done_count", done_count, exp_done);
      check("valid_cleared", out_valid, 0);
      check("busy_idle", busy, 0);
      check("pending_not_taken", core_msg, data);
   endtask

   initial begin
      reset     = 1'b0;
      key_ready = 1'b1;
      in_valid  = 1'b0;
      in_data   = '0;
      in_mode   = 1'b0;
      out_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_in_ready", in_ready, 0);
      check("rst_busy", busy, 0);
      check("rst_out_valid", out_valid, 0);
      check("rst_core_start", core_start, 0);
      check("rst_done_count", done_count, 0);
      check("rst_out_data", out_data, 0);
      check("rst_core_msg", core_msg, 0);
      reset = 1'b1;
      #1;
      check("in_ready_after_release", in_ready, 1);

      do_op(32'd65, 1'b1, 3, 0, 1'b0);
      check("enc_65", out_data, 2790);
      do_op(32'd2790, 1'b0, 2, 0, 1'b0);
      check("dec_2790", out_data, 65);
      // Core finish is still high from the decrypt; the capture must wait for the fresh pulse.
      do_op(32'd65, 1'b1, 4, 10, 1'b0);
      check("stale_enc_65", out_data, 2790);

      for (int k = 0; k < 8; k++) begin
         do_op(WIDTH'($urandom_range(3232, 0)), 1'($urandom_range(1, 0)),
               int'($urandom_range(6, 1)), int'($urandom_range(3, 0)), 1'($urandom_range(1, 0)));
      end

      // Reset in the middle of RUN.
      core_lat = 30;
      in_data  = 32'd123;
      in_mode  = 1'b1;
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (SETTLE + 6) @(posedge clk);
      #1;
      check("busy_in_run", busy, 1);
      reset     = 1'b0;
      key_ready = 1'b0;
      #1;
      check("midrst_busy", busy, 0);
      check("midrst_done_count", done_count, 0);
      check("midrst_core_msg", core_msg, 0);
      @(posedge clk); #1;
      check("midrst_out_valid", out_valid, 0);
      check("midrst_core_start", core_start, 0);
      check("midrst_out_data", out_data, 0);
      reset    = 1'b1;
      exp_done = 0;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         check("no_key_in_ready", in_ready, 0);
         check("no_key_out_valid", out_valid, 0);
      end
      key_ready = 1'b1;
      #1;
      check("key_in_ready", in_ready, 1);
      do_op(32'd42, 1'b1, 2, 1, 1'b0);

`ifdef RSA_SEQ_TIMEOUT_EN
      begin
         int tcyc;
         int saw_valid;
         check("err_before", err_timeout, 0);
         force_low = 1'b1;
         in_data   = 32'd77;
         in_mode   = 1'b1;
         in_valid  = 1'b1;
         @(posedge clk); #1;
         in_valid  = 1'b0;
         tcyc      = 0;
         saw_valid = 0;
         while (busy && tcyc < 400) begin
            @(posedge clk); #1;
            tcyc++;
            if (out_valid) saw_valid = 1;
         end
         check("timeout_cycles", tcyc, SETTLE + 2 + 1 + TIMEOUT);
         check("err_timeout", err_timeout, 1);
         check("timeout_no_valid", saw_valid, 0);
         check("timeout_done_count", done_count, exp_done);
         check("timeout_in_ready", in_ready, 1);
         force_low = 1'b0;
         repeat (3) @(posedge clk);
         #1;
         check("err_sticky", err_timeout, 1);
      end
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
